div8_restoring: RTL and testbench

- Sequential unsigned restoring divider: quotient = dividend / divisor, remainder = dividend % divisor.
- Performs one shift-and-subtract step per clock, using an 8-bit borrow-out subtractor.
- This subtractor is the inverse of the team's 8-bit carry-select adder; the divider is its first sequential consumer in the lab datapath.
- Start/busy/done handshake to a controlling FSM or testbench.

---
 rtl/div8_restoring_pkg.sv | 24 ++
 rtl/div8_restoring_sub8_borrow.sv | 52 +++++
 rtl/div8_restoring.sv | 169 ++++++++++++++++
 tb/tb_div8_restoring.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/div8_restoring_pkg.sv
// ---------------------------------------------------------------------------
// div8_restoring_pkg
//   Shared definitions for the sequential restoring divider and its
//   borrow-out subtractor.
//
//   Contents:
//     W_DEFAULT  - default operand/result width in bits
//     CW_DEFAULT - default iteration counter width (must be able to hold W)
//     state_t    - divider control states (IDLE, RUN, FIN)
// ---------------------------------------------------------------------------
package div8_restoring_pkg;

  localparam int W_DEFAULT  = 8;
  localparam int CW_DEFAULT = 4;

  // Encodings are fixed so that state values stay recognisable on a
  // waveform viewer and in any logic analyser capture of the lab datapath.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/div8_restoring_sub8_borrow.sv
// ---------------------------------------------------------------------------
// sub8_borrow
//   Combinational W-bit unsigned subtractor with borrow out, built as
//   a + ~b + 1 on a carry-select structure (mirror image of the lab's
//   carry-select adder).
//
//   Ports:
//     a    in  W  minuend
//     b    in  W  subtrahend
//     diff out W  a - b (modulo 2**W)
//     bout out 1  borrow out, high when a < b
// ---------------------------------------------------------------------------
import div8_restoring_pkg::*;

module sub8_borrow #(
  parameter int W = W_DEFAULT
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         bout
);

  // Low half is rippled; the high half is computed for both possible
  // carries in parallel and the low half's carry out picks one.
  localparam int LO = W / 2;
  localparam int HI = W - LO;

  logic [W-1:0]  b_inv;
  logic [LO:0]   lo_sum;
  logic [HI:0]   hi_sum_c0;
  logic [HI:0]   hi_sum_c1;
  logic [HI:0]   hi_sel;
  logic          cout;

  assign b_inv = ~b;

  // The "+1" of two's complement enters as the carry into the low half.
  assign lo_sum = {1'b0, a[LO-1:0]} + {1'b0, b_inv[LO-1:0]} + {{LO{1'b0}}, 1'b1};

  assign hi_sum_c0 = {1'b0, a[W-1:LO]} + {1'b0, b_inv[W-1:LO]};
  assign hi_sum_c1 = {1'b0, a[W-1:LO]} + {1'b0, b_inv[W-1:LO]} + {{HI{1'b0}}, 1'b1};

  assign hi_sel = lo_sum[LO] ? hi_sum_c1 : hi_sum_c0;

  assign diff = {hi_sel[HI-1:0], lo_sum[LO-1:0]};
  assign cout = hi_sel[HI];

  // With a + ~b + 1, a carry out means no borrow was needed.
  assign bout = ~cout;

endmodule

// File: rtl/div8_restoring.sv
// ---------------------------------------------------------------------------
// div8_restoring
//   Sequential unsigned restoring divider. One shift-and-subtract step per
//   clock; W steps per division. Divide-by-zero finishes immediately with
//   quotient all ones and remainder equal to the dividend.
//
//   Ports:
//     clk         in  1  rising-edge clock
//     rst         in  1  synchronous active-high reset
//     start       in  1  request, only looked at while idle
//     dividend    in  W  captured on the accepted start
//     divisor     in  W  captured on the accepted start
//     busy        out 1  high while iterating
//     done        out 1  one-cycle pulse when results become valid
//     quotient    out W  result, held until the next completion
//     remainder   out W  result, held until the next completion
//     div_by_zero out 1  set with done when divisor was 0, held like results
// ---------------------------------------------------------------------------
import div8_restoring_pkg::*;

module div8_restoring #(
  parameter int W  = W_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

  state_t        state, state_n;

  // Working registers: q shifts the dividend out and the quotient in,
  // r is the partial remainder, d the captured divisor.
  logic [W-1:0]  q_reg, q_n;
  logic [W-1:0]  r_reg, r_n;
  logic [W-1:0]  d_reg, d_n;
  logic [CW-1:0] cnt, cnt_n;

  // Result registers, only written at completion so they stay readable
  // while the next division is running.
  logic [W-1:0]  quo_reg, quo_n;
  logic [W-1:0]  rem_reg, rem_n;
  logic          dbz_reg, dbz_n;

  // One iteration's datapath.
  logic [W-1:0]  shift_low;
  logic          shift_top;
  logic [W-1:0]  sub_diff;
  logic          sub_bout;
  logic          ok;
  logic [W-1:0]  r_iter;
  logic [W-1:0]  q_iter;

  // {r, q[W-1]} is W+1 bits wide; the subtractor only sees the low W bits
  // and the top bit is folded into the accept decision below.
  assign shift_top = r_reg[W-1];
  assign shift_low = {r_reg[W-2:0], q_reg[W-1]};

  sub8_borrow #(
    .W (W)
  ) u_sub (
    .a    (shift_low),
    .b    (d_reg),
    .diff (sub_diff),
    .bout (sub_bout)
  );

  // If the shifted-out top bit is set, the shifted value is at least 2**W,
  // which always exceeds the divisor, so the subtraction is taken even
  // though the W-bit subtractor reports a borrow.
  assign ok     = shift_top | ~sub_bout;
  assign r_iter = ok ? sub_diff : shift_low;
  assign q_iter = {q_reg[W-2:0], ok};

  // State and datapath registers. Reset wins over every other action, so
  // an in-flight division is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      q_reg   <= '0;
      r_reg   <= '0;
      d_reg   <= '0;
      cnt     <= '0;
      quo_reg <= '0;
      rem_reg <= '0;
      dbz_reg <= 1'b0;
    end else begin
      state   <= state_n;
      q_reg   <= q_n;
      r_reg   <= r_n;
      d_reg   <= d_n;
      cnt     <= cnt_n;
      quo_reg <= quo_n;
      rem_reg <= rem_n;
      dbz_reg <= dbz_n;
    end
  end

  // Next-state and datapath control. Everything holds by default; only the
  // accept edge, the iteration edges and the completion edge change things.
  always_comb begin
    state_n = state;
    q_n     = q_reg;
    r_n     = r_reg;
    d_n     = d_reg;
    cnt_n   = cnt;
    quo_n   = quo_reg;
    rem_n   = rem_reg;
    dbz_n   = dbz_reg;

    case (state)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            // No iterations needed: publish the saturated result directly.
            quo_n   = '1;
            rem_n   = dividend;
            dbz_n   = 1'b1;
            state_n = FIN;
          end else begin
            q_n     = dividend;
            d_n     = divisor;
            r_n     = '0;
            cnt_n   = '0;
            state_n = RUN;
          end
        end
      end

      RUN: begin
        q_n   = q_iter;
        r_n   = r_iter;
        cnt_n = cnt + CW'(1);
        if (cnt == LAST_ITER) begin
          quo_n   = q_iter;
          rem_n   = r_iter;
          dbz_n   = 1'b0;
          state_n = FIN;
        end
      end

      FIN: begin
        // Start is deliberately not looked at here; a request must be
        // presented again once the divider is back in IDLE.
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy        = (state == RUN);
  assign done        = (state == FIN);
  assign quotient    = quo_reg;
  assign remainder   = rem_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_div8_restoring.sv
// ---------------------------------------------------------------------------
// tb_div8_restoring
//   Directed self-checking bench for div8_restoring. Expected values are
//   hand-computed constants next to each vector.
// ---------------------------------------------------------------------------
module tb_div8_restoring;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks   = 0;
  int failures = 0;

  // 10 time-unit clock period.
  always #5 clk = ~clk;

  div8_restoring #(
    .W  (W),
    .CW (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and land 1 unit after it, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a start request for exactly one edge (the accept edge).
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  // Count edges after the current point until done is seen, bounded.
  task automatic waitDone(input int limit, output int edges);
    edges = 0;
    while (done !== 1'b1 && edges < limit) begin
      step();
      edges++;
    end
  endtask

  // Full division: accept, latency, results, single-cycle done pulse.
  task automatic runDiv(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                        input logic exp_z);
    int edges;
    applyStimulus(a, b);
    checkOutput({tag, "_busy"}, busy, exp_z ? 0 : 1);
    waitDone(40, edges);
    checkOutput({tag, "_latency"}, edges, exp_z ? 0 : W);
    checkOutput({tag, "_quotient"}, quotient, exp_q);
    checkOutput({tag, "_remainder"}, remainder, exp_r);
    checkOutput({tag, "_dbz"}, div_by_zero, exp_z);
    step();
    checkOutput({tag, "_done_pulse"}, done, 0);
    checkOutput({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    int edges;
    int done_count;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    step();
    step();

    $display("[TB] reset state");
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_quotient", quotient, 0);
    checkOutput("rst_remainder", remainder, 0);
    checkOutput("rst_dbz", div_by_zero, 0);
    rst = 1'b0;
    step();

    $display("[TB] basic and extreme vectors");
    runDiv("basic_200_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
    runDiv("ext_255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
    runDiv("ext_255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
    runDiv("ext_5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
    runDiv("ext_0_3", 8'd0, 8'd3, 8'd0, 8'd0, 1'b0);
    runDiv("ext_128_3", 8'd128, 8'd3, 8'd42, 8'd2, 1'b0);

    $display("[TB] divide by zero");
    runDiv("dbz_100_0", 8'd100, 8'd0, 8'd255, 8'd100, 1'b1);
    runDiv("after_dbz_9_3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0);

    $display("[TB] start while busy");
    applyStimulus(8'd200, 8'd7);
    step();
    step();
    checkOutput("held_quotient", quotient, 3);
    checkOutput("held_remainder", remainder, 0);
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    step();
    start    = 1'b0;
    checkOutput("busy_start_still_busy", busy, 1);
    waitDone(40, edges);
    checkOutput("busy_start_latency", edges + 3, W);
    checkOutput("busy_start_quotient", quotient, 28);
    checkOutput("busy_start_remainder", remainder, 4);
    done_count = 0;
    for (int i = 0; i < W + 4; i++) begin
      step();
      if (done === 1'b1) done_count++;
    end
    checkOutput("busy_start_single_done", done_count, 0);

    $display("[TB] reset mid-operation");
    applyStimulus(8'd200, 8'd7);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_quotient", quotient, 0);
    checkOutput("midrst_remainder", remainder, 0);
    checkOutput("midrst_dbz", div_by_zero, 0);
    done_count = 0;
    for (int i = 0; i < W + 4; i++) begin
      step();
      if (done === 1'b1) done_count++;
    end
    checkOutput("midrst_no_done", done_count, 0);
    runDiv("after_rst_64_8", 8'd64, 8'd8, 8'd8, 8'd0, 1'b0);

    $display("[TB] back-to-back");
    applyStimulus(8'd17, 8'd4);
    waitDone(40, edges);
    checkOutput("b2b_first_quotient", quotient, 4);
    checkOutput("b2b_first_remainder", remainder, 1);
    dividend = 8'd13;
    divisor  = 8'd2;
    start    = 1'b1;
    step();
    checkOutput("b2b_fin_start_busy", busy, 0);
    checkOutput("b2b_fin_start_done", done, 0);
    step();
    start = 1'b0;
    checkOutput("b2b_accept_busy", busy, 1);
    waitDone(40, edges);
    checkOutput("b2b_done_spacing", edges + 2, W + 2);
    checkOutput("b2b_second_quotient", quotient, 6);
    checkOutput("b2b_second_remainder", remainder, 1);
    step();
    checkOutput("b2b_done_pulse", done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so a stuck run still terminates with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
